line_mem: RTL and testbench

LINE_MEM -- requirements
Module: line_mem

---
 rtl/mem_pkg.sv | 29 ++
 rtl/line_mem_if.sv | 30 +++
 rtl/lat_counter.sv | 29 ++
 rtl/line_mem.sv | 167 ++++++++++++++++
 tb/tb_line_mem.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the line memory model.
//   cmd_e   : 2-bit command encoding on command_in / command_out
//   state_e : line_mem controller states
//   fill_byte(): reset fill value of a byte, from its low address byte and the seed
package mem_pkg;

  typedef enum logic [1:0] {
    CmdNop       = 2'd0,
    CmdResponse  = 2'd1,
    CmdReadLine  = 2'd2,
    CmdWriteLine = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrCollect,
    StWait,
    StRdBurst,
    StWrAck
  } state_e;

  // Width of the reset epoch used to tag written lines.
  localparam int unsigned EpochW = 16;

  function automatic logic [7:0] fill_byte(logic [7:0] addr_lo, logic [7:0] seed);
    return addr_lo ^ seed;
  endfunction

endpackage

// File: rtl/line_mem_if.sv
// Command/data bus between a cache (master) and line_mem (slave).
//   address     : line address (byte address without the line offset)
//   command_in  : NOP / RESPONSE / READ_LINE / WRITE_LINE towards the memory
//   data_in     : write beat
//   command_out : NOP or RESPONSE from the memory
//   data_out    : read beat, zero when not driving
//   busy        : memory not idle
interface line_mem_if
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned BUS_W  = 16
);
  logic [ADDR_W-1:0] address;
  cmd_e              command_in;
  logic [BUS_W-1:0]  data_in;
  cmd_e              command_out;
  logic [BUS_W-1:0]  data_out;
  logic              busy;

  modport master (
    output address, command_in, data_in,
    input  command_out, data_out, busy
  );

  modport slave (
    input  address, command_in, data_in,
    output command_out, data_out, busy
  );
endinterface

// File: rtl/lat_counter.sv
// Loadable down-counter that stops at zero.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   i_load     : load i_value (has priority over i_dec)
//   i_dec      : decrement when nonzero
//   o_zero     : count is zero
module lat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);
endmodule

// File: rtl/line_mem.sv
// Behavioural main memory serving whole cache lines over a narrow bus.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high; idles the controller and restores the fill pattern
//   dump  : debug request, no effect on state or outputs
//   bus   : line_mem_if slave (address, command_in, data_in, command_out, data_out, busy)
// Reads return BEATS little-endian beats starting LATENCY cycles after acceptance.
// Writes collect BEATS beats, commit LATENCY cycles after the last one, then ack once.
module line_mem
  import mem_pkg::*;
#(
  parameter int unsigned MEM_ADDR_SIZE     = 19,
  parameter int unsigned BUS_SIZE          = 16,
  parameter int unsigned CACHE_OFFSET_SIZE = 4,
  parameter int unsigned CACHE_LINE_SIZE   = 16,
  parameter int unsigned LATENCY           = 100,
  parameter int unsigned SEED              = 0
) (
  input logic       clk,
  input logic       reset,
  input logic       dump,
  line_mem_if.slave bus
);
  localparam int unsigned LineAddrW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int unsigned NumLines  = 2 ** LineAddrW;
  localparam int unsigned LineBits  = CACHE_LINE_SIZE * 8;
  localparam int unsigned Beats     = LineBits / BUS_SIZE;
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned CntW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Lines are stored with the reset epoch they were written in; a line whose tag
  // differs from the current epoch has not been written since the last reset and
  // reads back as the fill pattern. This avoids clearing the whole array on reset.
  // The epoch wraps after 2**EpochW reset cycles.
  logic [LineBits-1:0] r_mem [NumLines];
  logic [EpochW-1:0]   r_tag [NumLines];
  logic [EpochW-1:0]   r_epoch;

  state_e              r_state;
  logic [LineAddrW-1:0] r_addr;
  logic [LineBits-1:0] r_wbuf;
  logic [BeatW-1:0]    r_beat;
  logic                r_is_write;
  cmd_e                r_cmd_out;
  logic [BUS_SIZE-1:0] r_data_out;
  logic                r_busy;

  logic [LineBits-1:0] w_fill;
  logic [LineBits-1:0] w_line;
  logic [BeatW-1:0]    w_next_beat;
  logic                w_last;
  logic                w_load;
  logic                w_zero;
  logic                w_commit;
  logic                w_unused_dump;

  assign w_unused_dump = dump;

  always_comb begin
    w_fill = '0;
    for (int b = 0; b < CACHE_LINE_SIZE; b++) begin
      w_fill[b*8 +: 8] = fill_byte(8'({r_addr, CACHE_OFFSET_SIZE'(b)}), 8'(SEED));
    end
  end

  assign w_line      = (r_tag[r_addr] == r_epoch) ? r_mem[r_addr] : w_fill;
  assign w_next_beat = r_beat + BeatW'(1);
  assign w_last      = (r_beat == BeatW'(Beats - 1));

  // Reload at acceptance and again at the last write beat; only WAIT counts down.
  assign w_load = ((r_state == StIdle) &&
                   ((bus.command_in == CmdReadLine) || (bus.command_in == CmdWriteLine))) ||
                  ((r_state == StWrCollect) && w_last);
  assign w_commit = !reset && (r_state == StWait) && w_zero && r_is_write;

  lat_counter #(
    .WIDTH (CntW)
  ) u_lat_counter (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (CntW'(LATENCY - 1)),
    .i_dec   (r_state == StWait),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_addr] <= r_wbuf;
      r_tag[r_addr] <= r_epoch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_wbuf     <= '0;
      r_beat     <= '0;
      r_is_write <= 1'b0;
      r_cmd_out  <= CmdNop;
      r_data_out <= '0;
      r_busy     <= 1'b0;
      r_epoch    <= r_epoch + EpochW'(1);
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.command_in == CmdReadLine) begin
            r_addr     <= bus.address;
            r_is_write <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StWait;
          end else if (bus.command_in == CmdWriteLine) begin
            r_addr                <= bus.address;
            r_wbuf[BUS_SIZE-1:0]  <= bus.data_in;
            r_is_write            <= 1'b1;
            r_busy                <= 1'b1;
            r_beat                <= (Beats > 1) ? BeatW'(1) : '0;
            r_state               <= (Beats > 1) ? StWrCollect : StWait;
          end
        end
        StWrCollect: begin
          r_wbuf[r_beat*BUS_SIZE +: BUS_SIZE] <= bus.data_in;
          if (w_last) begin
            r_beat  <= '0;
            r_state <= StWait;
          end else begin
            r_beat <= w_next_beat;
          end
        end
        StWait: begin
          if (w_zero) begin
            r_cmd_out <= CmdResponse;
            r_beat    <= '0;
            if (r_is_write) begin
              r_state <= StWrAck;
            end else begin
              r_data_out <= w_line[BUS_SIZE-1:0];
              r_state    <= StRdBurst;
            end
          end
        end
        StRdBurst: begin
          if (w_last) begin
            r_cmd_out  <= CmdNop;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_beat     <= '0;
            r_state    <= StIdle;
          end else begin
            r_beat     <= w_next_beat;
            r_data_out <= w_line[w_next_beat*BUS_SIZE +: BUS_SIZE];
          end
        end
        StWrAck: begin
          r_cmd_out <= CmdNop;
          r_busy    <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.command_out = r_cmd_out;
  assign bus.data_out    = r_data_out;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_line_mem.sv
// Directed bench for line_mem: LATENCY=4, 16-bit bus, 16-byte lines (8 beats), SEED=0.
module tb_line_mem;
  import mem_pkg::*;

  localparam int unsigned Lat = 4;

  logic clk;
  logic reset;
  logic dump;

  int unsigned n_vec;
  int unsigned n_fail;

  logic [15:0] exp_beats [8];
  logic [15:0] wr_beats  [8];

  line_mem_if #(.ADDR_W(15), .BUS_W(16)) bus_if ();

  line_mem #(
    .MEM_ADDR_SIZE     (19),
    .BUS_SIZE          (16),
    .CACHE_OFFSET_SIZE (4),
    .CACHE_LINE_SIZE   (16),
    .LATENCY           (Lat),
    .SEED              (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dump  (dump),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fill pattern beat j of a line with SEED=0: bytes (line*16+2j) and +1, low byte first.
  function automatic logic [15:0] fill_beat(input logic [14:0] line, input int j);
    logic [7:0] b;
    b = 8'(({line, 4'h0}) + 19'(2 * j));
    return {b + 8'd1, b};
  endfunction

  task automatic set_fill(input logic [14:0] line);
    for (int j = 0; j < 8; j++) exp_beats[j] = fill_beat(line, j);
  endtask

  task automatic do_read(input string tag, input logic [14:0] a);
    int n;
    bus_if.address    = a;
    bus_if.command_in = CmdReadLine;
    tick();
    bus_if.command_in = CmdNop;
    chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (bus_if.command_out == CmdResponse) break;
    end
    chk({tag, "_lat"}, 32'(n), 32'(Lat));
    for (int j = 0; j < 8; j++) begin
      if (j != 0) tick();
      chk({tag, "_rsp"}, 32'(bus_if.command_out), 32'(CmdResponse));
      chk({tag, "_beat"}, 32'(bus_if.data_out), 32'(exp_beats[j]));
    end
    tick();
    chk({tag, "_end_cmd"}, 32'(bus_if.command_out), 32'(CmdNop));
    chk({tag, "_end_data"}, 32'(bus_if.data_out), 32'd0);
    chk({tag, "_end_busy"}, 32'(bus_if.busy), 32'd0);
  endtask

  // Sends all 8 beats; collection beats carry a READ_LINE that must be ignored.
  task automatic send_write(input logic [14:0] a);
    bus_if.address    = a;
    bus_if.command_in = CmdWriteLine;
    bus_if.data_in    = wr_beats[0];
    tick();
    for (int j = 1; j < 8; j++) begin
      bus_if.command_in = CmdReadLine;
      bus_if.data_in    = wr_beats[j];
      tick();
    end
    bus_if.command_in = CmdNop;
    bus_if.data_in    = '0;
  endtask

  initial begin
    int n;
    int rsp;
    n_vec  = 0;
    n_fail = 0;
    dump   = 1'b0;
    bus_if.address    = '0;
    bus_if.command_in = CmdNop;
    bus_if.data_in    = '0;

    // Reset with a simultaneous command: reset wins.
    reset = 1'b1;
    bus_if.command_in = CmdReadLine;
    tick();
    tick();
    reset = 1'b0;
    bus_if.command_in = CmdNop;
    chk("rst_cmd", 32'(bus_if.command_out), 32'(CmdNop));
    chk("rst_data", 32'(bus_if.data_out), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    tick();
    chk("rst_idle_busy", 32'(bus_if.busy), 32'd0);

    // Fill pattern read of line 1, with dump asserted (no effect).
    dump = 1'b1;
    set_fill(15'h0001);
    chk("fill_first", 32'(exp_beats[0]), 32'h1110);
    chk("fill_last", 32'(exp_beats[7]), 32'h1F1E);
    do_read("rd1", 15'h0001);
    dump = 1'b0;

    // Write line 2, ack one cycle after edge 11.
    for (int j = 0; j < 8; j++) wr_beats[j] = 16'hA000 + 16'(j);
    send_write(15'h0002);
    chk("wr_busy", 32'(bus_if.busy), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (bus_if.command_out == CmdResponse) break;
    end
    chk("wr_lat", 32'(n), 32'(Lat));
    chk("wr_ack", 32'(bus_if.command_out), 32'(CmdResponse));
    tick();
    chk("wr_ack_end", 32'(bus_if.command_out), 32'(CmdNop));
    chk("wr_idle", 32'(bus_if.busy), 32'd0);

    for (int j = 0; j < 8; j++) exp_beats[j] = 16'hA000 + 16'(j);
    do_read("rd_after_wr", 15'h0002);

    // Reads issued while busy are ignored: one burst of line 3 only.
    bus_if.address    = 15'h0003;
    bus_if.command_in = CmdReadLine;
    tick();
    bus_if.address = 15'h0005;
    tick();
    tick();
    bus_if.command_in = CmdNop;
    rsp = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus_if.command_out == CmdResponse) begin
        if (rsp == 0) chk("busy_ign_beat0", 32'(bus_if.data_out), 32'h3130);
        rsp++;
      end
      tick();
    end
    chk("busy_ign_count", 32'(rsp), 32'd8);

    // Reset during write WAIT abandons the write and restores the fill pattern.
    for (int j = 0; j < 8; j++) wr_beats[j] = 16'hB000 + 16'(j);
    send_write(15'h0002);
    tick();
    tick();
    chk("wait_busy", 32'(bus_if.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("wrst_cmd", 32'(bus_if.command_out), 32'(CmdNop));
    chk("wrst_data", 32'(bus_if.data_out), 32'd0);
    chk("wrst_busy", 32'(bus_if.busy), 32'd0);
    set_fill(15'h0002);
    chk("fill2_first", 32'(exp_beats[0]), 32'h2120);
    do_read("rd_after_rst", 15'h0002);

    // Top line, no wrap.
    set_fill(15'h7FFF);
    chk("top_last", 32'(exp_beats[7]), 32'hFFFE);
    do_read("rd_top", 15'h7FFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
